// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: decodes BRANCH/JAL/JALR, resolves direction and target, flags
// mispredicts and misaligned targets. Optional statistics counters under BRU_STATS_EN.
module branch_resolve_unit #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned INST_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [INST_WIDTH-1:0] in_inst,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic                  in_pred_taken,
    input  logic [ADDR_WIDTH-1:0] in_pred_target,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_taken,
    output logic [ADDR_WIDTH-1:0] out_target,
    output logic [ADDR_WIDTH-1:0] out_link,
    output logic                  out_mispredict,
    output logic [ADDR_WIDTH-1:0] out_redirect_pc,
    output logic                  out_misaligned,
    output logic                  out_is_cf
`ifdef BRU_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  stat_cf_count,
    output logic [CNT_WIDTH-1:0]  stat_mispredict_count
`endif
);

    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] b_imm;
    logic [ADDR_WIDTH-1:0] j_imm;
    logic [ADDR_WIDTH-1:0] i_imm;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [ADDR_WIDTH-1:0] jalr_sum;
    logic                  op_eq;
    logic                  op_lt;
    logic                  op_ltu;

    assign opcode   = in_inst[6:0];
    assign funct3   = in_inst[14:12];
    assign b_imm    = {{(ADDR_WIDTH-13){in_inst[31]}}, in_inst[31], in_inst[7],
                       in_inst[30:25], in_inst[11:8], 1'b0};
    assign j_imm    = {{(ADDR_WIDTH-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                       in_inst[20], in_inst[30:21], 1'b0};
    assign i_imm    = {{(ADDR_WIDTH-12){in_inst[31]}}, in_inst[31:20]};
    assign pc_plus4 = in_pc + ADDR_WIDTH'(4);
    assign jalr_sum = in_rs1 + i_imm;
    assign op_eq    = (in_rs1 == in_rs2);
    assign op_lt    = ($signed(in_rs1) < $signed(in_rs2));
    assign op_ltu   = (in_rs1 < in_rs2);

    // Combinational resolution of the request currently on the input port.
    logic                  res_taken;
    logic [ADDR_WIDTH-1:0] res_target;
    logic                  res_is_cf;
    logic                  res_misaligned;
    logic                  res_mispredict;
    logic [ADDR_WIDTH-1:0] res_redirect;

    always_comb begin
        res_taken  = 1'b0;
        res_target = pc_plus4;
        res_is_cf  = 1'b0;
        case (opcode)
            OpBranch: begin
                res_is_cf  = 1'b1;
                res_target = in_pc + b_imm;
                case (funct3)
                    3'b000:  res_taken = op_eq;
                    3'b001:  res_taken = !op_eq;
                    3'b100:  res_taken = op_lt;
                    3'b101:  res_taken = !op_lt;
                    3'b110:  res_taken = op_ltu;
                    3'b111:  res_taken = !op_ltu;
                    default: res_taken = 1'b0;
                endcase
            end
            OpJal: begin
                res_is_cf  = 1'b1;
                res_taken  = 1'b1;
                res_target = in_pc + j_imm;
            end
            OpJalr: begin
                res_is_cf  = 1'b1;
                res_taken  = 1'b1;
                res_target = {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
            end
            default: ;
        endcase

        res_misaligned = res_taken & res_target[1];
        // A misaligned target traps instead of redirecting, so it never counts as a mispredict.
        res_mispredict = !res_misaligned &
                         ((res_taken != in_pred_taken) |
                          (res_taken & (res_target != in_pred_target)));
        res_redirect   = res_taken ? res_target : pc_plus4;
    end

    // Single-entry output register.
    logic                  valid_q, valid_d;
    logic                  taken_q;
    logic [ADDR_WIDTH-1:0] target_q;
    logic [ADDR_WIDTH-1:0] link_q;
    logic                  mispredict_q;
    logic [ADDR_WIDTH-1:0] redirect_q;
    logic                  misaligned_q;
    logic                  is_cf_q;
    logic                  accept;
    logic                  load;

    assign in_ready = !valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    assign load     = accept & !flush;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            target_q     <= '0;
            link_q       <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            misaligned_q <= 1'b0;
            is_cf_q      <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                taken_q      <= res_taken;
                target_q     <= res_target;
                link_q       <= pc_plus4;
                mispredict_q <= res_mispredict;
                redirect_q   <= res_redirect;
                misaligned_q <= res_misaligned;
                is_cf_q      <= res_is_cf;
            end
        end
    end

    assign out_valid       = valid_q;
    assign out_taken       = taken_q;
    assign out_target      = target_q;
    assign out_link        = link_q;
    assign out_mispredict  = mispredict_q;
    assign out_redirect_pc = redirect_q;
    assign out_misaligned  = misaligned_q;
    assign out_is_cf       = is_cf_q;

`ifdef BRU_STATS_EN
    logic                 out_hs;
    logic [CNT_WIDTH-1:0] cf_cnt_q;
    logic [CNT_WIDTH-1:0] mp_cnt_q;

    assign out_hs = valid_q & out_ready;

    // Saturating counters, bumped on each consumed result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cf_cnt_q <= '0;
            mp_cnt_q <= '0;
        end else begin
            if (out_hs && is_cf_q && (cf_cnt_q != '1)) begin
                cf_cnt_q <= cf_cnt_q + CNT_WIDTH'(1);
            end
            if (out_hs && mispredict_q && (mp_cnt_q != '1)) begin
                mp_cnt_q <= mp_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign stat_cf_count         = cf_cnt_q;
    assign stat_mispredict_count = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed corner cases plus randomized traffic
// compared against a queue-based reference model.
module tb_branch_resolve_unit;

    localparam int unsigned AW = 64;
    localparam int unsigned IW = 32;
`ifdef BRU_STATS_EN
    localparam int unsigned CW = 4;
`else
    localparam int unsigned CW = 32;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_pc;
    logic [IW-1:0] in_inst;
    logic [AW-1:0] in_rs1;
    logic [AW-1:0] in_rs2;
    logic          in_pred_taken;
    logic [AW-1:0] in_pred_target;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic          out_taken;
    logic [AW-1:0] out_target;
    logic [AW-1:0] out_link;
    logic          out_mispredict;
    logic [AW-1:0] out_redirect_pc;
    logic          out_misaligned;
    logic          out_is_cf;
`ifdef BRU_STATS_EN
    logic [CW-1:0] stat_cf_count;
    logic [CW-1:0] stat_mispredict_count;
`endif

    branch_resolve_unit #(
        .ADDR_WIDTH(AW),
        .INST_WIDTH(IW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_inst        (in_inst),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_pred_taken  (in_pred_taken),
        .in_pred_target (in_pred_target),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_taken      (out_taken),
        .out_target     (out_target),
        .out_link       (out_link),
        .out_mispredict (out_mispredict),
        .out_redirect_pc(out_redirect_pc),
        .out_misaligned (out_misaligned),
        .out_is_cf      (out_is_cf)
`ifdef BRU_STATS_EN
        ,
        .stat_cf_count        (stat_cf_count),
        .stat_mispredict_count(stat_mispredict_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              taken;
        longint unsigned target;
        longint unsigned link;
        bit              mispredict;
        longint unsigned redirect;
        bit              misaligned;
        bit              is_cf;
    } res_t;

    int     n_checks = 0;
    int     n_errors = 0;
    res_t   exp_q[$];
    longint exp_cf_cnt = 0;
    longint exp_mp_cnt = 0;
    longint cnt_max = (64'd1 << CW) - 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference resolution built from the instruction fields with plain arithmetic.
    function automatic res_t model(longint unsigned pc, bit [31:0] inst, longint unsigned rs1,
                                   longint unsigned rs2, bit pt, longint unsigned ptgt);
        res_t   r;
        int     op = int'(inst & 32'h7f);
        int     f3 = int'((inst >> 12) & 7);
        longint bimm = (inst[31] ? -4096 : 0) + longint'(inst[7]) * 2048
                       + longint'((inst >> 25) & 63) * 32 + longint'((inst >> 8) & 15) * 2;
        longint jimm = (inst[31] ? -(longint'(1) << 20) : 0) + longint'((inst >> 12) & 255) * 4096
                       + longint'(inst[20]) * 2048 + longint'((inst >> 21) & 1023) * 2;
        longint iimm = (inst[31] ? -2048 : 0) + longint'((inst >> 20) & 2047);
        r.taken  = 0;
        r.is_cf  = 0;
        r.target = pc + 4;
        r.link   = pc + 4;
        if (op == 'h63) begin
            r.is_cf  = 1;
            r.target = pc + longint'(bimm);
            case (f3)
                0: r.taken = (rs1 == rs2);
                1: r.taken = (rs1 != rs2);
                4: r.taken = (longint'(rs1) < longint'(rs2));
                5: r.taken = (longint'(rs1) >= longint'(rs2));
                6: r.taken = (rs1 < rs2);
                7: r.taken = (rs1 >= rs2);
                default: r.taken = 0;
            endcase
        end else if (op == 'h6f) begin
            r.is_cf = 1; r.taken = 1; r.target = pc + longint'(jimm);
        end else if (op == 'h67) begin
            r.is_cf = 1; r.taken = 1; r.target = (rs1 + longint'(iimm)) & ~64'd1;
        end
        r.misaligned = r.taken && ((r.target >> 1) & 1) == 1;
        r.mispredict = !r.misaligned && ((r.taken != pt) || (r.taken && r.target != ptgt));
        r.redirect   = r.taken ? r.target : pc + 4;
        return r;
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd0, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, 5'd0, 7'b1100111};
    endfunction

    // One clock: check in_ready, advance the model across the edge, then check outputs.
    task automatic cycle();
        bit   exp_ready;
        bit   acc;
        res_t r;
        #1;
        exp_ready = (exp_q.size() == 0) || out_ready;
        check_eq("in_ready", in_ready, exp_ready);
        acc = in_valid && exp_ready;
        r = model(in_pc, in_inst, in_rs1, in_rs2, in_pred_taken, in_pred_target);
        @(posedge clk);
        if (exp_q.size() != 0 && out_ready) begin
            if (exp_q[0].is_cf && exp_cf_cnt < cnt_max) exp_cf_cnt++;
            if (exp_q[0].mispredict && exp_mp_cnt < cnt_max) exp_mp_cnt++;
            void'(exp_q.pop_front());
        end
        if (flush) exp_q.delete();
        else if (acc) exp_q.push_back(r);
        #1;
        check_eq("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check_eq("out_taken", out_taken, exp_q[0].taken);
            check_eq("out_link", out_link, exp_q[0].link);
            check_eq("out_mispredict", out_mispredict, exp_q[0].mispredict);
            check_eq("out_redirect_pc", out_redirect_pc, exp_q[0].redirect);
            check_eq("out_misaligned", out_misaligned, exp_q[0].misaligned);
            check_eq("out_is_cf", out_is_cf, exp_q[0].is_cf);
            if (exp_q[0].is_cf) check_eq("out_target", out_target, exp_q[0].target);
        end
`ifdef BRU_STATS_EN
        check_eq("stat_cf_count", stat_cf_count, exp_cf_cnt);
        check_eq("stat_mispredict_count", stat_mispredict_count, exp_mp_cnt);
`endif
    endtask

    task automatic drive(input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] rs1,
                         input logic [63:0] rs2, input logic pt, input logic [63:0] ptgt);
        in_pc = pc; in_inst = inst; in_rs1 = rs1; in_rs2 = rs2;
        in_pred_taken = pt; in_pred_target = ptgt;
    endtask

    initial begin
        logic [63:0] held_target;
        logic [63:0] held_link;
        res_t        r;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #3;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_taken", out_taken, 0);
        check_eq("rst_out_target", out_target, 0);
        check_eq("rst_out_redirect", out_redirect_pc, 0);
        check_eq("rst_out_is_cf", out_is_cf, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // BEQ +16, equal operands, predicted not-taken
        in_valid = 1'b1;
        drive(64'h1000, enc_b(3'b000, 13'd16), 5, 5, 0, 0);
        cycle();
        check_eq("beq_taken", out_taken, 1);
        check_eq("beq_target", out_target, 64'h1010);
        check_eq("beq_mispredict", out_mispredict, 1);
        check_eq("beq_redirect", out_redirect_pc, 64'h1010);

        // JALR with bit 0 cleared, correctly predicted
        drive(64'h2000, enc_jalr(12'd2), 64'h3001, 0, 1, 64'h3002);
        cycle();
        check_eq("jalr_target", out_target, 64'h3002);
        check_eq("jalr_link", out_link, 64'h2004);
        check_eq("jalr_mispredict", out_mispredict, 0);

        drive(64'h400, enc_b(3'b100, 13'd8), '1, 1, 0, 0);
        cycle();
        check_eq("blt_taken", out_taken, 1);
        drive(64'h400, enc_b(3'b110, 13'd8), '1, 1, 0, 0);
        cycle();
        check_eq("bltu_taken", out_taken, 0);

        // JAL to a 2-byte aligned target
        drive(64'h0, enc_j(21'd6), 0, 0, 0, 0);
        cycle();
        check_eq("jal_misaligned", out_misaligned, 1);
        check_eq("jal_mispredict", out_mispredict, 0);

        // Backpressure: hold for 3 cycles, then stream
        out_ready = 1'b0;
        drive(64'h5000, enc_j(21'h100), 0, 0, 0, 0);
        cycle();
        held_target = out_target;
        held_link   = out_link;
        for (int i = 0; i < 3; i++) begin
            drive(64'h6000 + 64'(i * 16), enc_b(3'b001, 13'd32), i, 0, 1, 0);
            cycle();
            check_eq("stall_in_ready", in_ready, 0);
            check_eq("stall_target_held", out_target, held_target);
            check_eq("stall_link_held", out_link, held_link);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(64'h7000 + 64'(i * 4), enc_b(3'b000, 13'd64), i, 0, 0, 0);
            cycle();
            check_eq("stream_link", out_link, 64'h7004 + 64'(i * 4));
        end

        // Flush races an accept into an empty slot
        in_valid = 1'b0;
        cycle();
        in_valid = 1'b1; flush = 1'b1;
        drive(64'h8000, enc_j(21'd8), 0, 0, 0, 0);
        cycle();
        check_eq("flush_out_valid", out_valid, 0);
        flush = 1'b0;

        // Reset asserted while a result is stalled
        out_ready = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_out_target", out_target, 0);
        check_eq("midrst_out_link", out_link, 0);
        exp_q.delete(); exp_cf_cnt = 0; exp_mp_cnt = 0;
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("postrst_in_ready", in_ready, 1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] rnd = $urandom;
            logic [6:0]  op;
            logic [63:0] a = {$urandom, $urandom};
            logic [63:0] b = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: op = 7'b1100011;
                1: op = 7'b1101111;
                2: op = 7'b1100111;
                default: op = 7'b0110011;
            endcase
            if ($urandom_range(0, 2) == 0) b = a;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            drive({$urandom, $urandom}, {rnd[31:7], op}, a, b, $urandom_range(0, 1), 0);
            r = model(in_pc, in_inst, in_rs1, in_rs2, in_pred_taken, 0);
            in_pred_target = ($urandom_range(0, 1) == 0) ? r.target : {$urandom, $urandom};
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        cycle();

`ifdef BRU_STATS_EN
        // Non-control-flow predicted taken always mispredicts; push the counter past saturation
        in_valid = 1'b1;
        for (int i = 0; i < (1 << CW) + 1; i++) begin
            drive(64'h100, 32'h0000_0033, 0, 0, 1, 0);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check_eq("stat_mp_saturated", stat_mispredict_count, {CW{1'b1}});
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, meaning PC/operand/target width.
REQ-002 SHALL have parameter INST_WIDTH, default 32, meaning instruction width.
REQ-003 SHALL have parameter CNT_WIDTH, default 32, meaning statistics counter width.
REQ-004 SHALL have ports: clk in 1, sole clock; rst_n in 1, reset, asynchronous, active-low.
REQ-005 SHALL have ports: in_valid in 1, request valid; in_ready out 1, unit can accept.
REQ-006 SHALL have ports: in_pc in ADDR_WIDTH, instruction PC; in_inst in INST_WIDTH, instruction.
REQ-007 SHALL have ports: in_rs1, in_rs2 in ADDR_WIDTH, source operands; in_pred_taken in 1, predicted direction; in_pred_target in ADDR_WIDTH, predicted target.
REQ-008 SHALL have ports: flush in 1, kill in-flight result.
REQ-009 SHALL have ports: out_valid out 1; out_ready in 1; out_taken out 1; out_target out ADDR_WIDTH; out_link out ADDR_WIDTH (pc+4).
REQ-010 SHALL have ports: out_mispredict out 1; out_redirect_pc out ADDR_WIDTH; out_misaligned out 1; out_is_cf out 1 (instruction is branch/JAL/JALR).

Function
REQ-011 SHALL decode opcode inst[6:0]: 1100011 BRANCH, 1101111 JAL, 1100111 JALR; all others are non-control-flow.
REQ-012 SHALL form B-imm as sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],0}; target = pc + imm, modulo 2^ADDR_WIDTH.
REQ-013 SHALL form J-imm as sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],0}; target = pc + imm.
REQ-014 SHALL form JALR target as (rs1 + sign-extended inst[31:20]) with bit 0 cleared.
REQ-015 SHALL evaluate BRANCH funct3: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU; funct3 010/011 SHALL give taken=0.
REQ-016 SHALL set taken=1 for JAL/JALR, 0 for non-control-flow.
REQ-017 SHALL set mispredict = (taken != pred_taken) OR (taken AND target != pred_target).
REQ-018 SHALL set redirect_pc = taken ? target : pc+4.
REQ-019 SHALL set misaligned = taken AND target[1]; misaligned forces mispredict=0.
REQ-020 SHALL capture a request when in_valid AND in_ready; all outputs are registered, latency exactly 1 cycle.
REQ-021 SHALL drive in_ready = !out_valid OR out_ready (single-entry output register, full throughput).
REQ-022 SHALL hold all out_* stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on flush=1, clear out_valid next cycle and drop any same-cycle capture; flush wins over simultaneous accept.
REQ-024 SHALL keep out_* data fields unchanged when out_valid=0 (no requirement on content).

Reset
REQ-025 SHALL, on rst_n=0, asynchronously clear out_valid, out_taken, out_mispredict, out_misaligned, out_is_cf to 0 and out_target, out_link, out_redirect_pc to 0.
REQ-026 SHALL discard any in-flight result when reset asserts mid-operation; in_ready=1 after reset releases.

Configuration
REQ-027 SHALL, with BRU_STATS_EN defined, add outputs stat_cf_count and stat_mispredict_count (CNT_WIDTH each), incremented on each out_valid&out_ready handshake with out_is_cf=1 / out_mispredict=1 respectively, saturating at all-ones, cleared by reset.
REQ-028 SHALL, without BRU_STATS_EN, omit those ports and counters entirely; all other behaviour identical.

Verification
REQ-029 SHALL cover: pc=0x1000, BEQ imm=+16, rs1=rs2=5, pred_taken=0 -> next cycle out_taken=1, out_target=0x1010, out_mispredict=1, out_redirect_pc=0x1010.
REQ-030 SHALL cover: pc=0x2000, JALR rs1=0x3001 imm=+2, pred_taken=1 pred_target=0x3002 -> out_target=0x3002, out_link=0x2004, out_mispredict=0.
REQ-031 SHALL cover: BLT rs1=-1 rs2=1 -> taken=1; BLTU same operands -> taken=0.
REQ-032 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs held; out_ready=1 -> one result per cycle.
REQ-033 SHALL cover: flush with simultaneous accept -> out_valid=0 next cycle; rst_n low mid-stall -> out_valid=0 immediately.
REQ-034 SHALL cover: JAL pc=0x0 imm=+6 -> out_misaligned=1, out_mispredict=0; with BRU_STATS_EN, 2^CNT_WIDTH+1 mispredicts -> stat_mispredict_count saturates at all-ones.
